// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_off;

    // Rotate so that bit 0 is the current highest-priority requester.
    assign w_dbl = {req, req};
    assign w_rot = N_REQ'(w_dbl >> ptr);

    // Priority-encode the rotated vector (lowest bit wins).
    always_comb begin
        w_off = '0;
        if (w_rot[0])      w_off = SEL_W'(0);
        else if (w_rot[1]) w_off = SEL_W'(1);
        else if (w_rot[2]) w_off = SEL_W'(2);
        else if (w_rot[3]) w_off = SEL_W'(3);
    end

    // Un-rotate: offset from ptr back to an absolute index (wraps naturally).
    assign idx = w_off + ptr;
    assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, with a hold-time limit and registered data out.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             dout
);

    state_t            r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [N_REQ-1:0]  r_gnt;
    logic [SEL_W-1:0]  r_sel;
    logic              r_busy;
    logic              r_dout;

    state_t            w_state_nxt;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic              w_busy_nxt;
    logic              w_dout_nxt;

    logic              w_release;
    logic [SEL_W-1:0]  w_pick_ptr;
    logic [SEL_W-1:0]  w_idx;
    logic              w_any;

    // The holder lets go when it drops its request or its hold window is used up.
    assign w_release  = (r_state == GRANT) &&
                        (!req[r_sel] || (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)));
    // On release, arbitrate this cycle from the slot after the holder.
    assign w_pick_ptr = w_release ? (r_sel + SEL_W'(1)) : r_ptr;

    rr_pick4 u_pick (
        .req (req),
        .ptr (w_pick_ptr),
        .idx (w_idx),
        .any (w_any)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_dout_nxt  = r_busy ? din[r_sel] : 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = onehot(w_idx);
                    w_sel_nxt   = w_idx;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt  = w_pick_ptr;
                    w_hold_nxt = '0;
                    if (w_any) begin
                        // Back-to-back handover; may re-grant the same lone holder.
                        w_gnt_nxt  = onehot(w_idx);
                        w_sel_nxt  = w_idx;
                        w_busy_nxt = 1'b1;
                    end else begin
                        // sel deliberately keeps its last value.
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_dout     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_dout     <= w_dout_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign dout = r_dout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a randomized run against a model.
module tb_mux4_rr_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dout;

    int n_cmp;
    int n_err;

    // Reference model: who holds, how many cycles it has held, priority pointer.
    int         m_h;
    int         m_held;
    int         m_ptr;
    int         m_sel;
    logic       m_dout;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int search(input int p, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_h = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_dout = 1'b0;
    endtask

    // Advance the model by one rising edge given the inputs seen at that edge.
    task automatic model_step(input logic [3:0] r, input logic [3:0] d);
        int k;
        m_dout = (m_h >= 0) ? d[m_sel] : 1'b0;
        if (m_h < 0) begin
            k = search(m_ptr, r);
            if (k >= 0) begin m_h = k; m_sel = k; m_held = 1; end
        end else if (!r[m_h] || m_held == int'(MAX_HOLD)) begin
            m_ptr = (m_h + 1) % 4;
            k = search(m_ptr, r);
            if (k >= 0) begin m_h = k; m_sel = k; m_held = 1; end
            else m_h = -1;
        end else begin
            m_held++;
        end
    endtask

    function automatic logic [3:0] m_gnt();
        return (m_h >= 0) ? (4'b0001 << m_h) : 4'b0000;
    endfunction

    // Drive inputs at the falling edge, step the model, land on the next falling edge.
    task automatic step_cycle(input logic [3:0] r, input logic [3:0] d);
        req = r;
        din = d;
        model_step(r, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        din   = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0 || dout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: gnt=%b sel=%b busy=%b dout=%b, want 0000 00 0 0", gnt, sel, busy, dout);
        end
        step_cycle(4'b0100, 4'b0100);
        step_cycle(4'b0100, 4'b0100);
        n_cmp++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || dout !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pregrant: gnt=%b busy=%b dout=%b, want 0100 1 1", gnt, busy, dout);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0 || dout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: gnt=%b sel=%b busy=%b dout=%b, want 0000 00 0 0", gnt, sel, busy, dout);
        end
        @(negedge clk);
        reset = 1'b0;
        req = 4'b0000;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        step_cycle(4'b0100, 4'b0100);
        n_cmp++;
        if (gnt !== 4'b0100 || sel !== 2'b10 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b sel=%b busy=%b, want 0100 10 1", gnt, sel, busy);
        end
        step_cycle(4'b0100, 4'b0100);
        n_cmp++;
        if (dout !== 1'b1) begin
            n_err++;
            $display("FAIL single_dout: dout=%b, want 1", dout);
        end
        step_cycle(4'b0000, 4'b0100);
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'b10) begin
            n_err++;
            $display("FAIL single_release: gnt=%b busy=%b sel=%b, want 0000 0 10", gnt, busy, sel);
        end
        step_cycle(4'b0000, 4'b1111);
        n_cmp++;
        if (dout !== 1'b0) begin
            n_err++;
            $display("FAIL single_dout_idle: dout=%b, want 0", dout);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step_cycle(4'b1111, 4'b0000);
            exp_g = 4'b0001 << (((i - 1) / int'(MAX_HOLD)) % 4);
            n_cmp++;
            if (gnt !== exp_g || busy !== 1'b1 || sel !== 2'(((i - 1) / int'(MAX_HOLD)) % 4)) begin
                n_err++;
                $display("FAIL rotation[%0d]: gnt=%b sel=%b busy=%b, want gnt=%b busy=1", i, gnt, sel, busy, exp_g);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        step_cycle(4'b1001, 4'b0000);
        step_cycle(4'b1001, 4'b0000);
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL early_first: gnt=%b, want 0001", gnt);
        end
        step_cycle(4'b1000, 4'b0000);
        n_cmp++;
        if (gnt !== 4'b1000 || sel !== 2'b11 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL early_handover: gnt=%b sel=%b busy=%b, want 1000 11 1", gnt, sel, busy);
        end
        // With ptr=1 after requester 0 released, 3 hands back to 0 (ptr wraps to 0 after 3).
        step_cycle(4'b0011, 4'b0000);
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL early_wrap: gnt=%b, want 0001", gnt);
        end
    endtask

    task automatic test_lone_holder();
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step_cycle(4'b0010, 4'b0000);
            n_cmp++;
            if (gnt !== 4'b0010 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL lone_holder[%0d]: gnt=%b busy=%b, want 0010 1", i, gnt, busy);
            end
        end
        // After 12 cycles the holder is at a timeout boundary; a new request must win now.
        step_cycle(4'b0110, 4'b0000);
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL lone_timeout_handover: gnt=%b, want 0100", gnt);
        end
    endtask

    task automatic test_withdrawn();
        do_reset();
        step_cycle(4'b0010, 4'b0000);
        step_cycle(4'b0110, 4'b0000);
        step_cycle(4'b0010, 4'b0000);
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL withdrawn_hold: gnt=%b, want 0010", gnt);
        end
        step_cycle(4'b0000, 4'b0000);
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL withdrawn_idle: gnt=%b busy=%b, want 0000 0", gnt, busy);
        end
        step_cycle(4'b0000, 4'b0000);
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL withdrawn_stay_idle: gnt=%b, want 0000", gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
            else if ($urandom_range(7) == 0) r[$urandom_range(3)] = 1'b0;
            step_cycle(r, 4'($urandom_range(15)));
            n_cmp++;
            if (gnt !== m_gnt() || busy !== (m_h >= 0) || sel !== 2'(m_sel) || dout !== m_dout) begin
                n_err++;
                $display("FAIL random[%0d]: gnt=%b sel=%b busy=%b dout=%b, want %b %0d %0d %b",
                         i, gnt, sel, busy, dout, m_gnt(), m_sel, (m_h >= 0), m_dout);
            end
            n_cmp++;
            if (!$onehot0(gnt) || ((gnt != 4'b0000) !== busy) ||
                (busy && gnt !== (4'b0001 << sel))) begin
                n_err++;
                $display("FAIL invariant[%0d]: gnt=%b sel=%b busy=%b", i, gnt, sel, busy);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        req   = 4'b0000;
        din   = 4'b0000;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_lone_holder();
        test_withdrawn();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin controller that shares the team's 4:1 single-bit mux datapath between four requesters.
- Arbitrates four request lines and drives the 2-bit mux select.
- Registers the selected data bit.
- Enforces a maximum hold time so that no requester can starve the others.
- Sits between the requesting units and the mux4 datapath. Its sel output maps to the mux select pair: sel[1] is j1, sel[0] is j0.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one grant may last; legal range 1..15.
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 4: request lines; req[k] belongs to requester k.
- din, input, 4: mux data lanes; din[k] is requester k's data bit.
- gnt, output, 4: one-hot grant, registered; 4'b0000 when idle.
- sel, output, 2: registered index of the granted requester; drives mux select.
- busy, output, 1: high while any grant is held.
- dout, output, 1: registered mux output.

Behaviour:
- Reset (asynchronous, takes effect immediately, even mid-grant): gnt=0000, sel=00, busy=0, dout=0, ptr=0, hold_cnt=0, state=IDLE.
- ptr (2 bits) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- States: IDLE, GRANT.
- IDLE behaviour:
  - If req != 0: pick the first set bit in search order.
  - Next edge: gnt=onehot(k), sel=k, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req asserted to gnt is 1 cycle.
  - If req == 0: remain in IDLE; all outputs hold their idle values.
- GRANT, hold phase: hold_cnt increments each cycle.
- GRANT, release conditions: release occurs when req[sel]==0, or when hold_cnt==MAX_HOLD-1 (timeout, so the grant has lasted MAX_HOLD cycles).
- GRANT, on release:
  - ptr = sel+1 mod 4.
  - Re-arbitrate in the same cycle using the new ptr and the current req.
  - If any request wins, the next edge loads the new grant with no bubble cycle, and hold_cnt=0.
  - If no request wins, the next edge sets gnt=0000, busy=0, state=IDLE. sel keeps its last value.
- Timeout with only the holder requesting: the holder is re-granted immediately, gnt stays unchanged, and hold_cnt restarts at 0.
- Simultaneous events in one cycle (holder drops while others raise): release takes priority, and the new winner is chosen from the current req.
- A request that drops before it is granted is never granted. No request is latched.
- dout: at each edge, dout <= busy ? din[sel] : 0. dout therefore lags gnt and sel by 1 cycle.
- Invariants checked by the bench:
  - gnt is always one-hot or zero.
  - gnt != 0 exactly when busy=1.
  - When gnt != 0, gnt == onehot(sel).

Decomposition:
- Shared package mux4_arb_pkg holds:
  - Localparams N_REQ=4 and SEL_W=2.
  - State encodings IDLE=1'b0 and GRANT=1'b1.
- One sub-module, rr_pick4:
  - Purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: idx[1:0], any.
  - Implements the rotate, priority-encode, un-rotate sequence.
- The top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
1. Reset: assert reset mid-cycle during an active grant → gnt=0000, busy=0, sel=00 and dout=0 immediately, before the next clk edge.
2. Single requester: req=0100 at edge t → gnt=0100, sel=10, busy=1 at t+1. With din=0100, dout=1 at t+2. req drops at t+3 → gnt=0000, busy=0 at t+4.
3. Rotation with timeout: MAX_HOLD=4, req=1111 held continuously → grants 0001, 0010, 0100, 1000, 0001, each lasting exactly 4 cycles, with no idle cycle between grants.
4. Early release and fairness: ptr=0, req=1001 → requester 0 granted. Requester 0 drops after 2 cycles → gnt=1000 on the next edge, and ptr=1.
5. Lone holder timeout: MAX_HOLD=4, req=0010 held for 12 cycles → gnt=0010 and busy=1 continuously; hold_cnt sequence is 0,1,2,3,0,1,...
6. Skip of a withdrawn request: req=0110 while requester 1 holds; req[2] drops before requester 1 releases and req becomes 0000 → gnt=0000 and state returns to IDLE; requester 2 is never granted.
